// File: rtl/memctrl_mport_mem.sv
// Multi-port synchronous RAM: NUM_PORTS requesters share one DEPTH x DATA_WIDTH array.
// A combinational arbiter grants at most one access per clock (round-robin or fixed
// priority). Reads return registered data tagged with the issuing port, one cycle later.
module memctrl_mport_mem #(
  parameter int unsigned NUM_PORTS  = 4,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 256,
  parameter int unsigned ARB_MODE   = 0,
  // Derived widths; not meant to be overridden.
  parameter int unsigned PORT_W     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_PORTS-1:0]            req,
  input  logic [NUM_PORTS-1:0]            rw,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0] addr,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] datain,
  output logic [NUM_PORTS-1:0]            gnt,
  output logic [DATA_WIDTH-1:0]           dataout,
  output logic                            rd_valid,
  output logic [PORT_W-1:0]               rd_port,
  output logic                            addr_err
);

  localparam int unsigned MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // DEPTH fits in ADDR_WIDTH+1 bits because DEPTH <= 2**ADDR_WIDTH.
  localparam logic [ADDR_WIDTH:0] DEPTH_LIM = (ADDR_WIDTH + 1)'(DEPTH);

  // Arbitration state and registered outputs.
  logic [PORT_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [DATA_WIDTH-1:0] dataout_q;
  logic                  rd_valid_q;
  logic [PORT_W-1:0]     rd_port_q;
  logic                  addr_err_q;

  // Storage; intentionally not reset.
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  // Arbiter results and the winner's request fields.
  logic [PORT_W-1:0]     ptr_eff;
  logic [PORT_W-1:0]     win_idx;
  logic                  found;
  logic                  grant;
  logic                  sel_rw;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_data;
  logic                  in_range;
  logic [MEM_AW-1:0]     mem_idx;
  logic [DATA_WIDTH-1:0] rd_word;

  // Fixed priority is just round-robin with the scan start pinned at port 0.
  assign ptr_eff = (ARB_MODE == 1) ? '0 : rr_ptr_q;

  // Pick the winner: first requester at or above the pointer, else wrap to the lowest one.
  always_comb begin
    found   = 1'b0;
    win_idx = '0;
    for (int j = 0; j < NUM_PORTS; j++) begin
      if (!found && req[j] && (j >= int'(ptr_eff))) begin
        found   = 1'b1;
        win_idx = PORT_W'(j);
      end
    end
    for (int j = 0; j < NUM_PORTS; j++) begin
      if (!found && req[j]) begin
        found   = 1'b1;
        win_idx = PORT_W'(j);
      end
    end
  end

  // Reset masks the grant so no access, and hence no RAM write, can complete.
  assign grant = found & ~reset;

  // One-hot grant back to the requesters.
  always_comb begin
    gnt = '0;
    if (grant) begin
      gnt = NUM_PORTS'(1) << win_idx;
    end
  end

  // Route the winning port's direction, address and write data.
  always_comb begin
    sel_rw   = 1'b0;
    sel_addr = '0;
    sel_data = '0;
    for (int j = 0; j < NUM_PORTS; j++) begin
      if (PORT_W'(j) == win_idx) begin
        sel_rw   = rw[j];
        sel_addr = addr[j*ADDR_WIDTH +: ADDR_WIDTH];
        sel_data = datain[j*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign in_range = ({1'b0, sel_addr} < DEPTH_LIM);
  assign mem_idx  = sel_addr[MEM_AW-1:0];
  // Out-of-range index is never used: the read mux and write enable both gate on in_range.
  assign rd_word  = in_range ? mem_q[mem_idx] : '0;

  // Advance the round-robin pointer past the winner on every completed access.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (grant) begin
      if (win_idx == PORT_W'(NUM_PORTS - 1)) begin
        rr_ptr_d = '0;
      end else begin
        rr_ptr_d = win_idx + PORT_W'(1);
      end
    end
  end

  // Round-robin pointer register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end

  // RAM write port; out-of-range writes are dropped.
  always_ff @(posedge clk) begin
    if (grant && !sel_rw && in_range) begin
      mem_q[mem_idx] <= sel_data;
    end
  end

  // Read response and address-error flag, registered at the grant edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dataout_q  <= '0;
      rd_valid_q <= 1'b0;
      rd_port_q  <= '0;
      addr_err_q <= 1'b0;
    end else if (grant) begin
      rd_valid_q <= sel_rw;
      addr_err_q <= ~in_range;
      if (sel_rw) begin
        dataout_q <= rd_word;
        rd_port_q <= win_idx;
      end
    end else begin
      rd_valid_q <= 1'b0;
      addr_err_q <= 1'b0;
    end
  end

  assign dataout  = dataout_q;
  assign rd_valid = rd_valid_q;
  assign rd_port  = rd_port_q;
  assign addr_err = addr_err_q;

endmodule

// File: tb/tb_memctrl_mport_mem.sv
// Directed bench for memctrl_mport_mem: a round-robin instance (DEPTH=200) checked through
// a read/write scoreboard with a memory model, plus a fixed-priority instance.
module tb_memctrl_mport_mem;

  logic clk;
  logic reset;

  // Round-robin instance signals.
  logic [3:0]  req_r, rw_r, gnt_r;
  logic [31:0] addr_r, din_r;
  logic [7:0]  dout_r;
  logic        rdv_r, aerr_r;
  logic [1:0]  rdp_r;

  // Fixed-priority instance signals.
  logic [3:0]  req_f, rw_f, gnt_f;
  logic [31:0] addr_f, din_f;
  logic [7:0]  dout_f;
  logic        rdv_f, aerr_f;
  logic [1:0]  rdp_f;

  memctrl_mport_mem #(
    .NUM_PORTS (4),
    .ADDR_WIDTH(8),
    .DATA_WIDTH(8),
    .DEPTH     (200),
    .ARB_MODE  (0)
  ) u_rr (
    .clk     (clk),
    .reset   (reset),
    .req     (req_r),
    .rw      (rw_r),
    .addr    (addr_r),
    .datain  (din_r),
    .gnt     (gnt_r),
    .dataout (dout_r),
    .rd_valid(rdv_r),
    .rd_port (rdp_r),
    .addr_err(aerr_r)
  );

  memctrl_mport_mem #(
    .NUM_PORTS (4),
    .ADDR_WIDTH(8),
    .DATA_WIDTH(8),
    .DEPTH     (256),
    .ARB_MODE  (1)
  ) u_fp (
    .clk     (clk),
    .reset   (reset),
    .req     (req_f),
    .rw      (rw_f),
    .addr    (addr_f),
    .datain  (din_f),
    .gnt     (gnt_f),
    .dataout (dout_f),
    .rd_valid(rdv_f),
    .rd_port (rdp_f),
    .addr_err(aerr_f)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       is_rd;
    logic       err;
    logic [1:0] port;
    logic [7:0] data;
  } sb_t;

  sb_t        sb[$];
  logic [7:0] mdl [256];
  logic [7:0] last_dout;
  int         n_vec;
  int         n_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_port(input int p, input logic r, input logic rd, input logic [7:0] a,
                          input logic [7:0] d);
    req_r[p]         = r;
    rw_r[p]          = rd;
    addr_r[p*8 +: 8] = a;
    din_r[p*8 +: 8]  = d;
  endtask

  // One clock of the round-robin DUT; w is the port expected to win (-1 = none).
  task automatic cycle_rr(input int w);
    sb_t        e;
    logic [7:0] a;
    #2;
    if (w < 0) begin
      chk("gnt_idle", {28'd0, gnt_r}, 32'd0);
    end else begin
      chk($sformatf("gnt_p%0d", w), {28'd0, gnt_r}, 32'd1 << w);
      a       = addr_r[w*8 +: 8];
      e.is_rd = rw_r[w];
      e.err   = (a >= 8'd200);
      e.port  = 2'(w);
      e.data  = e.err ? 8'h00 : mdl[a];
      if (!e.is_rd && !e.err) mdl[a] = din_r[w*8 +: 8];
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("rd_valid", {31'd0, rdv_r}, {31'd0, e.is_rd});
      chk("addr_err", {31'd0, aerr_r}, {31'd0, e.err});
      if (e.is_rd) begin
        chk("rd_port", {30'd0, rdp_r}, {30'd0, e.port});
        last_dout = e.data;
      end
    end else begin
      chk("rd_valid_idle", {31'd0, rdv_r}, 32'd0);
      chk("addr_err_idle", {31'd0, aerr_r}, 32'd0);
    end
    chk("dataout", {24'd0, dout_r}, {24'd0, last_dout});
  endtask

  initial begin
    n_vec     = 0;
    n_err     = 0;
    last_dout = 8'h00;
    reset     = 1'b1;
    req_r = '0; rw_r = '0; addr_r = '0; din_r = '0;
    req_f = '0; rw_f = '0; addr_f = '0; din_f = '0;

    // Reset state, with every port requesting: grant must stay low.
    repeat (2) @(posedge clk);
    #1;
    req_r = 4'hF;
    #2;
    chk("rst_gnt", {28'd0, gnt_r}, 32'd0);
    chk("rst_dataout", {24'd0, dout_r}, 32'd0);
    chk("rst_rd_valid", {31'd0, rdv_r}, 32'd0);
    chk("rst_rd_port", {30'd0, rdp_r}, 32'd0);
    chk("rst_addr_err", {31'd0, aerr_r}, 32'd0);
    @(posedge clk);
    #1;
    req_r = '0;
    reset = 1'b0;

    // Port 2 writes 0xA5 to 0x10, then reads it back.
    set_port(2, 1'b1, 1'b0, 8'h10, 8'hA5);
    cycle_rr(2);
    set_port(2, 1'b1, 1'b1, 8'h10, 8'h00);
    cycle_rr(2);

    // Seed distinct data at 0x30+p from each port in turn.
    req_r = '0;
    for (int p = 0; p < 4; p++) begin
      req_r = '0;
      set_port(p, 1'b1, 1'b0, 8'h30 + 8'(p), 8'h40 + 8'(p));
      cycle_rr(p);
    end

    // Reset pulse with a write pending: pointer returns to 0 and RAM is untouched.
    req_r = '0;
    set_port(0, 1'b1, 1'b0, 8'h30, 8'hEE);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Round-robin: all ports hold reads; expect 0,1,2,3,0,1.
    for (int p = 0; p < 4; p++) set_port(p, 1'b1, 1'b1, 8'h30 + 8'(p), 8'h00);
    cycle_rr(0);
    cycle_rr(1);
    cycle_rr(2);
    cycle_rr(3);
    cycle_rr(0);
    cycle_rr(1);

    // Idle cycles: no grant, rd_valid drops, dataout holds.
    req_r = '0;
    cycle_rr(-1);
    cycle_rr(-1);

    // Back-to-back write then read of the same address from different ports.
    set_port(0, 1'b1, 1'b0, 8'h20, 8'h3C);
    cycle_rr(0);
    req_r = '0;
    set_port(3, 1'b1, 1'b1, 8'h20, 8'h00);
    cycle_rr(3);

    // Range boundary: 199 is the last word, 200 and 0xF0 are out of range.
    req_r = '0;
    set_port(1, 1'b1, 1'b0, 8'd199, 8'h5A);
    cycle_rr(1);
    set_port(1, 1'b1, 1'b1, 8'd199, 8'h00);
    cycle_rr(1);
    set_port(1, 1'b1, 1'b1, 8'hF0, 8'h00);
    cycle_rr(1);
    set_port(1, 1'b1, 1'b0, 8'hF0, 8'h77);
    cycle_rr(1);
    set_port(1, 1'b1, 1'b0, 8'd200, 8'h66);
    cycle_rr(1);
    set_port(1, 1'b1, 1'b1, 8'hF0, 8'h00);
    cycle_rr(1);
    set_port(1, 1'b1, 1'b1, 8'd199, 8'h00);
    cycle_rr(1);

    // Reset right after a read completes; then pointer must restart at 0.
    req_r = '0;
    set_port(0, 1'b1, 1'b1, 8'h10, 8'h00);
    cycle_rr(0);
    reset = 1'b1;
    #1;
    chk("midrst_rd_valid", {31'd0, rdv_r}, 32'd0);
    chk("midrst_dataout", {24'd0, dout_r}, 32'd0);
    last_dout = 8'h00;
    req_r = '0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    set_port(2, 1'b1, 1'b1, 8'h32, 8'h00);
    set_port(0, 1'b1, 1'b1, 8'h20, 8'h00);
    cycle_rr(0);
    cycle_rr(2);
    cycle_rr(0);
    req_r = '0;
    cycle_rr(-1);

    // Fixed priority: ports 1 and 3 hold reads; port 1 wins until it drops.
    req_f = 4'b1010;
    rw_f  = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      #2;
      chk("fp_gnt_p1", {28'd0, gnt_f}, 32'b0010);
      @(posedge clk);
      #1;
      chk("fp_rd_valid", {31'd0, rdv_f}, 32'd1);
      chk("fp_rd_port1", {30'd0, rdp_f}, 32'd1);
    end
    req_f = 4'b1000;
    #2;
    chk("fp_gnt_p3", {28'd0, gnt_f}, 32'b1000);
    @(posedge clk);
    #1;
    chk("fp_rd_port3", {30'd0, rdp_f}, 32'd3);
    req_f = 4'b1001;
    #2;
    chk("fp_gnt_p0", {28'd0, gnt_f}, 32'b0001);
    @(posedge clk);
    #1;
    chk("fp_rd_port0", {30'd0, rdp_f}, 32'd0);
    req_f = 4'b0000;
    #2;
    chk("fp_gnt_idle", {28'd0, gnt_f}, 32'd0);
    @(posedge clk);
    #1;
    chk("fp_rd_valid_idle", {31'd0, rdv_f}, 32'd0);
    chk("fp_addr_err", {31'd0, aerr_f}, 32'd0);

    if (sb.size() != 0) begin
      n_err++;
      $error("FAIL sb_drain: observed %0d expected 0", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/memctrl_mport_mem.md
Name: memctrl_mport_mem

Overview:
- Parametrised successor to the single-port 8-bit memory DUT: NUM_PORTS requesters share one synchronous RAM of DEPTH words × DATA_WIDTH bits.
- An arbiter grants at most one access per clock. Reads return registered data tagged with the port index.
- Sits behind the memctrl testbench shell as the next-generation DUT. Each port is driven by its own bench channel.

Parameters:
- NUM_PORTS, 4, number of requester ports (1..8).
- ADDR_WIDTH, 8, address width per port.
- DATA_WIDTH, 8, data width.
- DEPTH, 256, words implemented (≤ 2**ADDR_WIDTH).
- ARB_MODE, 0, 0 = round-robin, 1 = fixed priority (port 0 highest).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- req  in  NUM_PORTS  per-port access request.
- rw  in  NUM_PORTS  per-port direction: 1 = read, 0 = write.
- addr  in  NUM_PORTS*ADDR_WIDTH  per-port address; port p uses bits [p*ADDR_WIDTH +: ADDR_WIDTH].
- datain  in  NUM_PORTS*DATA_WIDTH  per-port write data, same packing.
- gnt  out  NUM_PORTS  one-hot grant, combinational, same cycle as req.
- dataout  out  DATA_WIDTH  registered read data.
- rd_valid  out  1  dataout valid this cycle.
- rd_port  out  clog2(NUM_PORTS) (min 1)  port that issued the read now on dataout.
- addr_err  out  1  registered; granted access had addr ≥ DEPTH.

Behaviour:
- Reset values:
  - gnt = 0, dataout = 0, rd_valid = 0, rd_port = 0, addr_err = 0.
  - Round-robin pointer rr_ptr = 0.
  - RAM contents are not reset.
- While reset is high:
  - gnt is forced to 0 and no RAM write occurs.
  - Reset asserted mid-read clears rd_valid immediately (asynchronous).
- Arbitration is combinational from req and rr_ptr:
  - ARB_MODE=0: winner is the first asserted req scanning from rr_ptr upward, wrapping NUM_PORTS-1 → 0.
  - ARB_MODE=1: winner is the lowest-index asserted req; rr_ptr is ignored.
  - gnt[w] = 1 only for the winner. gnt = 0 when req = 0.
- Transfer:
  - An access completes on the rising edge where req[w] & gnt[w].
  - Requester holds req, rw, addr and datain stable until it sees gnt high at that edge.
  - Requester may deassert req or present a new request in the next cycle.
- Write (rw=0): RAM[addr_w] ← datain_w at the grant edge. rd_valid = 0 the next cycle.
- Read (rw=1): dataout, rd_port = w and rd_valid = 1 are registered at the grant edge, giving 1-cycle latency.
  - With no read granted, rd_valid returns to 0 the next cycle.
  - dataout holds its last value.
- Write then read of the same address in consecutive cycles returns the new data.
- rr_ptr (ARB_MODE=0):
  - On each grant edge, rr_ptr ← (w+1) mod NUM_PORTS.
  - Unchanged on cycles with no grant.
- Out-of-range address (addr ≥ DEPTH) when granted:
  - The access is still consumed; gnt behaves normally.
  - Write is dropped.
  - Read returns dataout = 0 with rd_valid = 1.
  - addr_err = 1 for one cycle, aligned with rd_valid.
- Back-to-back grants to different ports are allowed every cycle; sustained throughput is one access per clock.
- Starvation bound (ARB_MODE=0): a held request is granted within NUM_PORTS cycles.
- Unused high bits of rd_port are 0.

Test Plan:
- Reset then single port: assert reset, check all outputs 0. Release; port 2 writes 0xA5 to 0x10, then reads 0x10 → gnt=4'b0100 both cycles; next cycle after read, rd_valid=1, dataout=0xA5, rd_port=2.
- Round-robin fairness: ARB_MODE=0, all 4 ports hold read req from reset → grants in order 0,1,2,3,0,1 on consecutive cycles. rd_port sequence lags grants by one cycle.
- Fixed priority: ARB_MODE=1, ports 1 and 3 hold req → port 1 granted every cycle. Port 3 is granted only after port 1 deasserts.
- Back-to-back coherency: port 0 writes 0x3C to 0x20; next cycle port 3 reads 0x20 → dataout=0x3C, rd_port=3.
- Out-of-range: DEPTH=200, port 1 reads 0xF0 → rd_valid=1, dataout=0, addr_err=1. A write to 0xF0 leaves RAM unchanged and pulses addr_err.
- Reset mid-operation: assert reset in the cycle after a read grant → rd_valid drops immediately. After release, rr_ptr=0: with ports 2 and 0 requesting, port 0 is granted first.
